// File: rtl/debounce_pkg.sv
// Shared constants, types and helpers for the debounce_bank switch debouncer.
package debounce_pkg;

    localparam int MAX_CH    = 32;
    localparam int CNT_W_MAX = 32;

    // Generic view of one channel's filter state; each channel sizes its own counter.
    typedef struct packed {
        logic                 stable;
        logic [CNT_W_MAX-1:0] cnt;
    } ch_state_t;

    function automatic int ms_to_cycles(input int clock_hz, input int ms);
        return (clock_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, symmetric press/release filter, optional long-press.
// Long-press hold counter is built only when DEBOUNCE_BANK_LONGPRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = 500_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_switch,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int   CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic IDLE_RAW = ACTIVE_LOW;

    logic [1:0]       sync;
    logic             pressed;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{IDLE_RAW}};
        end else begin
            sync <= {sync[0], i_switch};
        end
    end

    assign pressed = sync[1] ^ ACTIVE_LOW;
    assign accept  = (pressed != stable) && (cnt == CNT_W'(DB_CYCLES - 1));

    // Any cycle that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable    <= 1'b0;
            cnt       <= '0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            if (pressed == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable    <= pressed;
                cnt       <= '0;
                o_press   <= pressed;
                o_release <= !pressed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_level = stable;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold;
    logic              long_done;
    logic              long_q;

    // Counting starts the cycle after press acceptance, so the pulse lands LONG_CYCLES edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (accept) begin
                hold      <= '0;
                long_done <= 1'b0;
            end else if (stable && !long_done) begin
                if (hold == HOLD_W'(LONG_CYCLES - 1)) begin
                    long_q    <= 1'b1;
                    long_done <= 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

    assign o_long = long_q;
`else
    logic unused_cfg;
    assign unused_cfg = (LONG_CYCLES == 0);
    assign o_long     = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: N_CH independent debounce_channel instances.
// Optional long-press strobe enabled by defining DEBOUNCE_BANK_LONGPRESS_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CLOCK_RATE_HZ = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int ACTIVE_LOW    = 1,
    parameter int LONG_MS       = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_switch,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long
);

    localparam int DB_CYCLES   = ms_to_cycles(CLOCK_RATE_HZ, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(CLOCK_RATE_HZ, LONG_MS);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .ACTIVE_LOW  (ACTIVE_LOW != 0)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_switch  (i_switch[ch]),
            .o_level   (o_level[ch]),
            .o_press   (o_press[ch]),
            .o_release (o_release[ch]),
            .o_long    (o_long[ch])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random switching vs a window model.
module tb_debounce_bank;

    localparam int N_CH = 4;
    localparam int DB   = 10;
    localparam int LONG = 50;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] sw = '1;
    logic [N_CH-1:0] o_level, o_press, o_release, o_long;

    int checks   = 0;
    int failures = 0;

    debounce_bank #(
        .N_CH          (N_CH),
        .CLOCK_RATE_HZ (10_000),
        .DEBOUNCE_MS   (1),
        .ACTIVE_LOW    (1),
        .LONG_MS       (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_switch  (sw),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 clk = ~clk;

    // Reference model: raw pressed samples per edge since reset; a level flips once the
    // input seen through the 2-edge synchroniser has been the opposite level for DB edges.
    bit              rq [N_CH][$];
    bit              sq [N_CH][$];
    bit [N_CH-1:0]   m_level, m_press, m_release, m_long;
    int              k;
    int              press_edge [N_CH];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_press = '0; m_release = '0; m_long = '0;
        if (!rst_n) begin
            k = 0; m_level = '0;
            for (int c = 0; c < N_CH; c++) begin
                rq[c].delete(); sq[c].delete(); press_edge[c] = -100000;
            end
            return;
        end
        k++;
        for (int c = 0; c < N_CH; c++) begin
            bit seen, all_opp;
            rq[c].push_back(!sw[c]);
            seen = (rq[c].size() >= 3) ? rq[c][rq[c].size()-3] : 1'b0;
            sq[c].push_back(seen);
            all_opp = (sq[c].size() >= DB);
            for (int j = 0; j < DB && all_opp; j++)
                if (sq[c][sq[c].size()-1-j] == m_level[c]) all_opp = 0;
            if (all_opp) begin
                m_level[c]   = !m_level[c];
                m_press[c]   = m_level[c];
                m_release[c] = !m_level[c];
                if (m_level[c]) press_edge[c] = k;
            end
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
            m_long[c] = m_level[c] && (k - press_edge[c] == LONG);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("level",   int'(o_level),   int'(m_level));
        check("press",   int'(o_press),   int'(m_press));
        check("release", int'(o_release), int'(m_release));
        check("long",    int'(o_long),    int'(m_long));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // which: 0 press, 1 release, 2 long. n = edges until seen, -1 on timeout.
    task automatic wait_bit(input int ch, input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit && n < 0; i++) begin
            tick();
            case (which)
                0:       if (o_press[ch])   n = i;
                1:       if (o_release[ch]) n = i;
                default: if (o_long[ch])    n = i;
            endcase
        end
    endtask

    int n, cnt_long, bounce_strobes;

    initial begin
        // reset state
        rst_n = 1'b0; sw = '1;
        ticks(3);
        check("rst_level", int'(o_level), 0);
        check("rst_strobes", int'({o_press, o_release, o_long}), 0);
        @(negedge clk) rst_n = 1'b1;
        ticks(20);

        // clean press on ch0
        sw[0] = 1'b0;
        wait_bit(0, 0, 40, n);
        check("clean_press_lat", n, 12);
        check("clean_others", int'(o_level[3:1]), 0);
        tick();
        check("clean_press_1cyc", int'(o_press[0]), 0);
        ticks(10);

        // release with glitch back to pressed
        sw[0] = 1'b1; ticks(3);
        sw[0] = 1'b0; ticks(5);
        sw[0] = 1'b1;
        wait_bit(0, 1, 40, n);
        check("glitch_release_lat", n, 12);
        check("glitch_level", int'(o_level[0]), 0);

        // bouncing ch1
        bounce_strobes = 0;
        for (int t = 0; t < 10; t++) begin
            sw[1] = ~sw[1];
            for (int i = 0; i < 4; i++) begin
                tick();
                bounce_strobes += int'(o_press[1]) + int'(o_release[1]);
            end
        end
        check("bounce_no_strobe", bounce_strobes, 0);
        sw[1] = 1'b0;
        wait_bit(1, 0, 40, n);
        check("bounce_press_lat", n, 12);

        // all channels pressed on the same edge
        sw = '1; ticks(20);
        sw = '0;
        wait_bit(0, 0, 40, n);
        check("sim_lat", n, 12);
        check("sim_press", int'(o_press), 4'hF);
        tick();
        check("sim_press_off", int'(o_press), 0);
        check("sim_level", int'(o_level), 4'hF);

        // reset mid-count on ch2
        sw = '1; ticks(20);
        sw[2] = 1'b0;
        ticks(8);
        rst_n = 1'b0;
        #1;
        check("midrst_level", int'(o_level), 0);
        check("midrst_strobes", int'({o_press, o_release, o_long}), 0);
        ticks(3);
        @(negedge clk) rst_n = 1'b1;
        wait_bit(2, 0, 40, n);
        check("midrst_press_lat", n, 12);

        // long press on ch3
        sw = '1; ticks(20);
        sw[3] = 1'b0;
        wait_bit(3, 0, 40, n);
        check("long_press_lat", n, 12);
        wait_bit(3, 2, 100, n);
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        check("long_lat", n, LONG);
`else
        check("long_absent", n, -1);
`endif
        cnt_long = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            cnt_long += int'(o_long[3]);
        end
        check("long_no_repeat", cnt_long, 0);
        sw[3] = 1'b1; ticks(20);
        sw[3] = 1'b0; ticks(30);
        sw[3] = 1'b1;
        cnt_long = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            cnt_long += int'(o_long[3]);
        end
        check("short_hold_no_long", cnt_long, 0);

        // random switching, all channels
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 9) == 0) sw[c] = ~sw[c];
            if (i % 300 == 150) sw = $urandom_range(0, 15);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
